// File: rtl/ddr_pkg.sv
// -----------------------------------------------------------------------------
// ddr_pkg
// Shared types and width helpers for the DDR word packer slice.
//   ddr_state_e : alignment state (HUNT until the sync pattern is seen)
//   ddr_match_e : where the sync pattern was found among the two samples
//   fill_w()    : width of the fill index for a word of `count` samples
//   cnt_w()     : width of a sample count in 0..count
// -----------------------------------------------------------------------------
package ddr_pkg;

  typedef enum logic {
    DDR_HUNT   = 1'b0,
    DDR_LOCKED = 1'b1
  } ddr_state_e;

  typedef enum logic [1:0] {
    DDR_MATCH_NONE    = 2'd0,
    DDR_MATCH_FALLING = 2'd1,
    DDR_MATCH_RISING  = 2'd2
  } ddr_match_e;

  function automatic int fill_w(input int count);
    return $clog2(count);
  endfunction

  function automatic int cnt_w(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/ddr_word_packer_if.sv
// -----------------------------------------------------------------------------
// ddr_word_packer_if
// Bundles the sample inputs, control strobes and word outputs of the packer.
//   slave  : the packer (samples/controls in, word out)
//   master : upstream source plus downstream consumer (samples/controls out,
//            word in)
// Parameters: width (sample bits), count (samples per word).
// -----------------------------------------------------------------------------
interface ddr_word_packer_if #(
  parameter int width = 8,
  parameter int count = 4
) ();

  logic                               rising_valid;
  logic [width-1:0]                   rising;
  logic                               falling_valid;
  logic [width-1:0]                   falling;
  logic                               flush;
  logic                               resync;
  logic                               dout_valid;
  logic [width*count-1:0]             dout;
  logic [ddr_pkg::cnt_w(count)-1:0]   dout_count;
  logic                               locked;

  modport slave (
    input  rising_valid, rising, falling_valid, falling, flush, resync,
    output dout_valid, dout, dout_count, locked
  );

  modport master (
    output rising_valid, rising, falling_valid, falling, flush, resync,
    input  dout_valid, dout, dout_count, locked
  );

endinterface

// File: rtl/ddr_sync_detect.sv
// -----------------------------------------------------------------------------
// ddr_sync_detect
// Compares the falling and rising samples of one cycle against the sync
// pattern and reports the first (oldest) match. Falling is older, so it wins
// when both match.
//   i_falling_valid / i_falling : older sample of the cycle
//   i_rising_valid  / i_rising  : newer sample of the cycle
//   o_match                     : DDR_MATCH_NONE / _FALLING / _RISING
// -----------------------------------------------------------------------------
module ddr_sync_detect
  import ddr_pkg::*;
#(
  parameter int               width = 8,
  parameter logic [width-1:0] sync  = 8'hA5
) (
  input  logic             i_falling_valid,
  input  logic [width-1:0] i_falling,
  input  logic             i_rising_valid,
  input  logic [width-1:0] i_rising,
  output ddr_match_e       o_match
);

  always_comb begin
    o_match = DDR_MATCH_NONE;
    if (i_falling_valid && (i_falling == sync)) begin
      o_match = DDR_MATCH_FALLING;
    end else if (i_rising_valid && (i_rising == sync)) begin
      o_match = DDR_MATCH_RISING;
    end
  end

endmodule

// File: rtl/ddr_word_packer.sv
// -----------------------------------------------------------------------------
// ddr_word_packer
// Packs the falling/rising sample streams of a DDR demultiplexer into words of
// `count` samples in arrival order (falling before rising within a cycle).
// No backpressure: the source cannot stall.
//
// Ports:
//   reset_n : asynchronous active-low reset
//   clock   : clock
//   bus     : ddr_word_packer_if.slave
//             in : rising_valid, rising, falling_valid, falling, flush, resync
//             out: dout_valid (1-cycle strobe), dout (sample 0 in LSBs),
//                  dout_count (valid samples in dout), locked
//
// Configuration macro: DDR_PACKER_ALIGN_EN
//   defined   : HUNT/LOCKED aligner; the first sample equal to `sync` becomes
//               sample 0 of a word, earlier samples are dropped.
//   undefined : no aligner; locked rises one cycle after reset and stays set.
// -----------------------------------------------------------------------------
module ddr_word_packer
  import ddr_pkg::*;
#(
  parameter int               width = 8,
  parameter int               count = 4,
  parameter logic [width-1:0] sync  = 8'hA5
) (
  input  logic               reset_n,
  input  logic               clock,
  ddr_word_packer_if.slave   bus
);

  localparam int             FW   = fill_w(count);
  localparam int             CW   = cnt_w(count);
  localparam logic [FW-1:0]  LAST = FW'(count - 1);

  // Accumulator and registered outputs
  logic [width-1:0]       r_buf [count];
  logic [FW-1:0]          r_fill;
  logic                   r_dout_valid;
  logic [width*count-1:0] r_dout;
  logic [CW-1:0]          r_dout_count;
  logic                   r_locked;

  // Next-cycle values
  logic [width-1:0]       w_buf [count];
  logic [FW-1:0]          w_idx;
  logic                   w_emit;
  logic [width*count-1:0] w_word;
  logic [CW-1:0]          w_word_cnt;
  logic [1:0]             w_take;     // {rising, falling} samples accepted
  logic [1:0]             w_n_take;
  logic                   w_flush_ok;
  logic [width-1:0]       w_smp [2];  // index 0 is the older (falling) sample

  assign w_smp[0] = bus.falling;
  assign w_smp[1] = bus.rising;

`ifdef DDR_PACKER_ALIGN_EN
  ddr_state_e r_state;
  ddr_match_e w_match;
  logic       w_lock;

  ddr_sync_detect #(
    .width (width),
    .sync  (sync)
  ) u_sync_detect (
    .i_falling_valid (bus.falling_valid),
    .i_falling       (bus.falling),
    .i_rising_valid  (bus.rising_valid),
    .i_rising        (bus.rising),
    .o_match         (w_match)
  );

  // In HUNT only the matching sample and anything after it in the same cycle
  // is kept; the fill index is always 0 in HUNT, so the match lands at slot 0.
  always_comb begin
    w_take     = {bus.rising_valid, bus.falling_valid};
    w_flush_ok = 1'b1;
    w_lock     = 1'b0;
    if (r_state == DDR_HUNT) begin
      w_flush_ok = 1'b0;
      unique case (w_match)
        DDR_MATCH_FALLING: w_lock = 1'b1;
        DDR_MATCH_RISING: begin
          w_take = 2'b10;
          w_lock = 1'b1;
        end
        default: w_take = 2'b00;
      endcase
    end
  end
`else
  wire [width-1:0] w_unused_sync = sync;

  always_comb begin
    w_take     = {bus.rising_valid, bus.falling_valid};
    w_flush_ok = 1'b1;
  end
`endif

  assign w_n_take = {1'b0, w_take[0]} + {1'b0, w_take[1]};

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned (which would infer a latch); blocking '=' is used
  // here because later statements read the values just computed.
  always_comb begin
    w_buf      = r_buf;
    w_idx      = r_fill;
    w_emit     = 1'b0;
    w_word     = r_dout;
    w_word_cnt = r_dout_count;

    if (bus.resync) begin
      w_idx = '0;
    end else begin
      // A flush emits the partial word only if this cycle's samples would not
      // complete it anyway; otherwise the full word goes out and the flush is
      // absorbed.
      if (w_flush_ok && bus.flush && (r_fill != '0) &&
          ((int'(r_fill) + int'(w_n_take)) < count)) begin
        w_emit = 1'b1;
        for (int i = 0; i < count; i++) begin
          w_word[i*width +: width] = (i < int'(r_fill)) ? r_buf[i] : '0;
        end
        w_word_cnt = CW'(r_fill);
        w_idx      = '0;
      end

      for (int k = 0; k < 2; k++) begin
        if (w_take[k]) begin
          w_buf[w_idx] = w_smp[k];
          if (w_idx == LAST) begin
            w_emit = 1'b1;
            for (int i = 0; i < count; i++) begin
              w_word[i*width +: width] = w_buf[i];
            end
            w_word_cnt = CW'(count);
            w_idx      = '0;
          end else begin
            w_idx = w_idx + 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the sample buffer carries no reset; slots at or beyond the fill
  // index are never exposed (full words overwrite every slot, flushes mask).
  always_ff @(posedge clock) begin
    r_buf <= w_buf;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fill       <= '0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_dout_count <= '0;
      r_locked     <= 1'b0;
`ifdef DDR_PACKER_ALIGN_EN
      r_state      <= DDR_HUNT;
`endif
    end else begin
      r_fill       <= w_idx;
      r_dout_valid <= w_emit;
      r_dout       <= w_word;
      r_dout_count <= w_word_cnt;
`ifdef DDR_PACKER_ALIGN_EN
      if (bus.resync) begin
        r_state  <= DDR_HUNT;
        r_locked <= 1'b0;
      end else if (w_lock) begin
        r_state  <= DDR_LOCKED;
        r_locked <= 1'b1;
      end
`else
      r_locked     <= 1'b1;
`endif
    end
  end

  assign bus.dout_valid = r_dout_valid;
  assign bus.dout       = r_dout;
  assign bus.dout_count = r_dout_count;
  assign bus.locked     = r_locked;

endmodule

// File: tb/tb_ddr_word_packer.sv
// -----------------------------------------------------------------------------
// tb_ddr_word_packer
// Directed scenarios followed by random traffic for ddr_word_packer
// (width=8, count=4, sync=A5). A queue-based reference model predicts
// every cycle's outputs. Works with or without DDR_PACKER_ALIGN_EN.
// -----------------------------------------------------------------------------
module tb_ddr_word_packer;

  localparam int         W     = 8;
  localparam int         C     = 4;
  localparam logic [7:0] SYNC  = 8'hA5;
`ifdef DDR_PACKER_ALIGN_EN
  localparam bit         ALIGN = 1'b1;
`else
  localparam bit         ALIGN = 1'b0;
`endif

  logic reset_n;
  logic clock;

  ddr_word_packer_if #(.width(W), .count(C)) bus ();

  ddr_word_packer #(.width(W), .count(C), .sync(SYNC)) dut (
    .reset_n (reset_n),
    .clock   (clock),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  part[$];
  bit          m_locked;
  logic        exp_valid;
  logic [31:0] exp_dout;
  logic [2:0]  exp_cnt;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] q[$]);
    logic [31:0] w = '0;
    foreach (q[i]) w[i*8 +: 8] = q[i];
    return w;
  endfunction

  task automatic model_reset();
    part.delete();
    m_locked  = 1'b0;
    exp_valid = 1'b0;
    exp_dout  = '0;
    exp_cnt   = '0;
  endtask

  // One clock edge worth of the packing rules, on queues.
  task automatic model_cycle(input bit fv, input logic [7:0] f,
                             input bit rv, input logic [7:0] r,
                             input bit fl, input bit rs);
    logic [7:0] smp[$];
    exp_valid = 1'b0;
    if (!ALIGN) m_locked = 1'b1;
    if (fv) smp.push_back(f);
    if (rv) smp.push_back(r);
    if (rs) begin
      part.delete();
      if (ALIGN) m_locked = 1'b0;
    end else if (!m_locked) begin
      while (smp.size() > 0 && smp[0] != SYNC) void'(smp.pop_front());
      if (smp.size() > 0) begin
        m_locked = 1'b1;
        part = smp;
      end
    end else begin
      if (fl && part.size() > 0 && part.size() + smp.size() < C) begin
        exp_valid = 1'b1;
        exp_dout  = pack(part);
        exp_cnt   = 3'(part.size());
        part.delete();
      end
      foreach (smp[i]) begin
        part.push_back(smp[i]);
        if (part.size() == C) begin
          exp_valid = 1'b1;
          exp_dout  = pack(part);
          exp_cnt   = 3'(C);
          part.delete();
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"},  32'(bus.dout_valid), 32'(exp_valid));
    check({tag, ".dout"},   bus.dout,            exp_dout);
    check({tag, ".count"},  32'(bus.dout_count), 32'(exp_cnt));
    check({tag, ".locked"}, 32'(bus.locked),     32'(m_locked));
  endtask

  // Called at a falling edge: drive, clock once, check at the next falling edge.
  task automatic step(input string tag, input bit fv, input logic [7:0] f,
                      input bit rv, input logic [7:0] r,
                      input bit fl, input bit rs);
    bus.falling_valid = fv;
    bus.falling       = fv ? f : 8'($urandom);
    bus.rising_valid  = rv;
    bus.rising        = rv ? r : 8'($urandom);
    bus.flush         = fl;
    bus.resync        = rs;
    model_cycle(fv, f, rv, r, fl, rs);
    @(posedge clock);
    @(negedge clock);
    compare_all(tag);
  endtask

  initial begin
    bus.falling_valid = 1'b0;
    bus.falling       = '0;
    bus.rising_valid  = 1'b0;
    bus.rising        = '0;
    bus.flush         = 1'b0;
    bus.resync        = 1'b0;
    reset_n           = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    compare_all("reset");
    reset_n = 1'b1;

`ifdef DDR_PACKER_ALIGN_EN
    // Alignment: 10 dropped, A5 becomes sample 0
    step("align1", 1, 8'h10, 1, 8'hA5, 0, 0);
    check("align_locked", 32'(bus.locked), 32'd1);
    step("align2", 1, 8'hB0, 1, 8'hB1, 0, 0);
    step("align3", 1, 8'hB2, 0, 8'h00, 0, 0);
    check("align_word", bus.dout, 32'hB2B1B0A5);
`endif

    // Both edges valid
    step("both1", 1, 8'h01, 1, 8'h02, 0, 0);
    check("both1_novalid", 32'(bus.dout_valid), 32'd0);
    step("both2", 1, 8'h03, 1, 8'h04, 0, 0);
    check("both_word", bus.dout, 32'h04030201);
    check("both_count", 32'(bus.dout_count), 32'd4);

    // Straddling a word boundary
    step("strad1", 1, 8'h0A, 1, 8'h0B, 0, 0);
    step("strad2", 1, 8'h0C, 0, 8'h00, 0, 0);
    step("strad3", 1, 8'h05, 1, 8'h06, 0, 0);
    check("strad_word", bus.dout, 32'h050C0B0A);
    step("strad4", 1, 8'h07, 1, 8'h08, 0, 0);
    step("strad5", 1, 8'h09, 0, 8'h00, 0, 0);
    check("strad_next", bus.dout, 32'h09080706);

    // Flush of a partial word with one new sample arriving
    step("flush1", 1, 8'h11, 1, 8'h22, 0, 0);
    step("flush2", 1, 8'h33, 0, 8'h00, 1, 0);
    check("flush_word", bus.dout, 32'h00002211);
    check("flush_count", 32'(bus.dout_count), 32'd2);
    step("flush3", 1, 8'h44, 1, 8'h55, 0, 0);
    step("flush4", 0, 8'h00, 1, 8'h66, 0, 0);
    check("flush_next", bus.dout, 32'h66554433);

    // Flush absorbed: the two new samples complete the word
    step("absorb1", 1, 8'h77, 1, 8'h88, 0, 0);
    step("absorb2", 1, 8'h99, 1, 8'hAA, 1, 0);
    check("absorb_word", bus.dout, 32'hAA998877);
    check("absorb_count", 32'(bus.dout_count), 32'd4);

    // Flush with an empty accumulator does nothing
    step("flush_empty", 0, 8'h00, 0, 8'h00, 1, 0);
    check("flush_empty_valid", 32'(bus.dout_valid), 32'd0);

    // resync together with flush, fill = 3
    step("rs1", 1, 8'h0D, 1, 8'h0E, 0, 0);
    step("rs2", 1, 8'h0F, 0, 8'h00, 0, 0);
    step("rs3", 1, 8'hD0, 1, 8'hD1, 1, 1);
    check("rs_novalid", 32'(bus.dout_valid), 32'd0);
    check("rs_locked", 32'(bus.locked), ALIGN ? 32'd0 : 32'd1);
    step("rs4", 1, 8'hA5, 1, 8'hC1, 0, 0);
    step("rs5", 1, 8'hC2, 1, 8'hC3, 0, 0);
    check("rs_word", bus.dout, 32'hC3C2C1A5);

    // Idle cycle: outputs hold
    step("hold", 0, 8'h00, 0, 8'h00, 0, 0);
    check("hold_word", bus.dout, 32'hC3C2C1A5);

    // Asynchronous reset mid-word
    step("mid1", 1, 8'hD1, 1, 8'hD2, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step("post1", 1, 8'hA5, 1, 8'hE1, 0, 0);
    step("post2", 1, 8'hE2, 1, 8'hE3, 0, 0);
    check("post_word", bus.dout, 32'hE3E2E1A5);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit         fv, rv, fl, rs;
      logic [7:0] f, r;
      fv = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
      r  = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
      fl = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 19) == 0);
      step("rand", fv, f, rv, r, fl, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
